// File: rtl/drr_pkg.sv
// Shared types and helpers for the weighted deficit-round-robin scheduler.
// Contents: FSM state enum, default-width data typedefs, saturating adder.
package drr_pkg;

    localparam int QUEUE_CNT_DEF = 8;
    localparam int SIZE_W_DEF    = 16;
    localparam int QUANTUM_W_DEF = 16;
    localparam int DEFICIT_W_DEF = 18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        SERVE  = 2'd2,
        SETTLE = 2'd3
    } state_e;

    typedef logic [SIZE_W_DEF-1:0]            size_t;
    typedef logic [QUANTUM_W_DEF-1:0]         quantum_t;
    typedef logic [DEFICIT_W_DEF-1:0]         deficit_t;
    typedef logic [$clog2(QUEUE_CNT_DEF)-1:0] qidx_t;

    // a + b clamped to 2^w - 1; operands are zero-extended into 32 bits so
    // the same helper serves any deficit width up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_v;
        max_v = (33'd1 << w) - 33'd1;
        sum   = {1'b0, a} + {1'b0, b};
        if (sum > max_v) begin
            return max_v[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/drr_next_sel.sv
// Rotating-priority finder: returns the first requesting index at or after
// start_i (incl_i=1) or strictly after start_i (incl_i=0), wrapping around.
// Ports: req_i request vector, start_i search origin, incl_i inclusive flag,
//        found_o any hit, idx_o hit index (0 when none).
module drr_next_sel #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    input  logic             incl_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found_s;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] cand_s;

    // Linear scan over N rotated positions; first hit wins.
    always_comb begin
        found_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        cand_s  = {IDX_W{1'b0}};
        for (int k = 0; k < N; k++) begin
            cand_s = IDX_W'((int'(start_i) + k + (incl_i ? 0 : 1)) % N);
            if (!found_s && req_i[cand_s]) begin
                found_s = 1'b1;
                idx_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign found_o = found_s;
    assign idx_o   = idx_s;

endmodule

// File: rtl/wdrr_scheduler.sv
// Weighted deficit-round-robin scheduler. Visits eligible queues in turn,
// credits each visit with its quantum, and grants head packets while the
// deficit covers them and the per-visit burst cap is not reached.
// Ports: clk_i, srst_n_i (sync active-low), quantum_i per-queue quantum
//        (0 disables), nempty_i / size_i head-of-line status, ready_i
//        downstream accept; read_o / read_val_o / read_size_o registered grant.
module wdrr_scheduler
    import drr_pkg::*;
#(
    parameter int QUEUE_CNT = 8,
    parameter int SIZE_W    = 16,
    parameter int QUANTUM_W = 16,
    parameter int DEFICIT_W = 18,
    parameter int MAX_BURST = 16
) (
    input  logic                                clk_i,
    input  logic                                srst_n_i,
    input  logic [QUEUE_CNT-1:0][QUANTUM_W-1:0] quantum_i,
    input  logic [QUEUE_CNT-1:0]                nempty_i,
    input  logic [QUEUE_CNT-1:0][SIZE_W-1:0]    size_i,
    input  logic                                ready_i,
    output logic [$clog2(QUEUE_CNT)-1:0]        read_o,
    output logic                                read_val_o,
    output logic [SIZE_W-1:0]                   read_size_o
);

    localparam int IDX_W   = $clog2(QUEUE_CNT);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [DEFICIT_W-1:0] deficit_q [QUEUE_CNT];
    logic [DEFICIT_W-1:0] deficit_d [QUEUE_CNT];
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [IDX_W-1:0]     read_q, read_d;
    logic                 read_val_q, read_val_d;
    logic [SIZE_W-1:0]    read_size_q, read_size_d;

    logic [QUEUE_CNT-1:0] eligible_s;
    logic                 sel_found_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic                 advance_s;
    logic                 head_fits_s;

    // A queue competes only with a head packet and a non-zero quantum.
    always_comb begin
        eligible_s = {QUEUE_CNT{1'b0}};
        for (int q = 0; q < QUEUE_CNT; q++) begin
            eligible_s[q] = nempty_i[q] && (quantum_i[q] != {QUANTUM_W{1'b0}});
        end
    end

    // IDLE may restart on the current pointer; advancing from SERVE must move on.
    drr_next_sel #(.N(QUEUE_CNT), .IDX_W(IDX_W)) u_next_sel (
        .req_i   (eligible_s),
        .start_i (ptr_q),
        .incl_i  (state_q == IDLE),
        .found_o (sel_found_s),
        .idx_o   (sel_idx_s)
    );

    assign head_fits_s = (DEFICIT_W'(size_i[ptr_q]) <= deficit_q[ptr_q]);

    // Next-state, deficit bookkeeping and grant generation.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        deficit_d   = deficit_q;
        burst_d     = burst_q;
        read_d      = read_q;
        read_val_d  = 1'b0;
        read_size_d = read_size_q;
        advance_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found_s) begin
                    ptr_d   = sel_idx_s;
                    state_d = CREDIT;
                end else begin
                    state_d = IDLE;
                end
            end
            CREDIT: begin
                deficit_d[ptr_q] = DEFICIT_W'(sat_add(32'(deficit_q[ptr_q]),
                                                      32'(quantum_i[ptr_q]),
                                                      DEFICIT_W));
                burst_d = {BURST_W{1'b0}};
                state_d = SERVE;
            end
            SERVE: begin
                if (!eligible_s[ptr_q]) begin
                    // Emptied or disabled queue forfeits its credit.
                    deficit_d[ptr_q] = {DEFICIT_W{1'b0}};
                    advance_s        = 1'b1;
                end else if (head_fits_s && (burst_q < BURST_W'(MAX_BURST))) begin
                    if (ready_i) begin
                        read_val_d       = 1'b1;
                        read_d           = ptr_q;
                        read_size_d      = size_i[ptr_q];
                        deficit_d[ptr_q] = deficit_q[ptr_q] - DEFICIT_W'(size_i[ptr_q]);
                        burst_d          = burst_q + BURST_W'(1);
                        state_d          = SETTLE;
                    end else begin
                        state_d = SERVE;
                    end
                end else begin
                    advance_s = 1'b1;
                end
            end
            SETTLE: begin
                // One bubble so the queue can present its next head.
                state_d = SERVE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance_s) begin
            if (sel_found_s) begin
                ptr_d   = sel_idx_s;
                state_d = CREDIT;
            end else begin
                state_d = IDLE;
            end
        end else begin
            advance_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q     <= IDLE;
            ptr_q       <= {IDX_W{1'b0}};
            burst_q     <= {BURST_W{1'b0}};
            read_q      <= {IDX_W{1'b0}};
            read_val_q  <= 1'b0;
            read_size_q <= {SIZE_W{1'b0}};
            for (int q = 0; q < QUEUE_CNT; q++) begin
                deficit_q[q] <= {DEFICIT_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            burst_q     <= burst_d;
            read_q      <= read_d;
            read_val_q  <= read_val_d;
            read_size_q <= read_size_d;
            for (int q = 0; q < QUEUE_CNT; q++) begin
                deficit_q[q] <= deficit_d[q];
            end
        end
    end

    assign read_o      = read_q;
    assign read_val_o  = read_val_q;
    assign read_size_o = read_size_q;

endmodule

// File: tb/tb_wdrr_scheduler.sv
// Self-checking bench for wdrr_scheduler (4 queues, burst cap 4): directed
// scenarios with literal expectations plus a randomized phase, all checked
// cycle by cycle against a behavioural reference model.
module tb_wdrr_scheduler;

    localparam int NQ   = 4;
    localparam int SW   = 16;
    localparam int QW   = 16;
    localparam int DW   = 18;
    localparam int MB   = 4;
    localparam longint DMAX = (64'd1 << DW) - 1;

    logic                clk;
    logic                srst_n_i;
    logic [NQ-1:0][QW-1:0] quantum_i;
    logic [NQ-1:0]       nempty_i;
    logic [NQ-1:0][SW-1:0] size_i;
    logic                ready_i;
    logic [1:0]          read_o;
    logic                read_val_o;
    logic [SW-1:0]       read_size_o;

    wdrr_scheduler #(.QUEUE_CNT(NQ), .SIZE_W(SW), .QUANTUM_W(QW),
                     .DEFICIT_W(DW), .MAX_BURST(MB)) dut (
        .clk_i       (clk),
        .srst_n_i    (srst_n_i),
        .quantum_i   (quantum_i),
        .nempty_i    (nempty_i),
        .size_i      (size_i),
        .ready_i     (ready_i),
        .read_o      (read_o),
        .read_val_o  (read_val_o),
        .read_size_o (read_size_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // packet queues feeding the DUT
    int unsigned pq [NQ][$];

    // reference model
    int     m_phase;   // 0 waiting, 1 crediting, 2 serving, 3 bubble
    int     m_ptr;
    longint m_def [NQ];
    int     m_burst;
    bit     exp_val;
    int     exp_q;
    int     exp_size;

    int gcnt = 0;
    int cntq [NQ];
    int glog [$];

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int find_next(input int start, input bit incl, input bit el [NQ]);
        for (int k = 0; k < NQ; k++) begin
            int c;
            c = (start + k + (incl ? 0 : 1)) % NQ;
            if (el[c]) return c;
        end
        return -1;
    endfunction

    // Model: one scheduling decision per rising edge from the visible inputs.
    initial begin
        m_phase = 0; m_ptr = 0; m_burst = 0;
        exp_val = 0; exp_q = 0; exp_size = 0;
        foreach (m_def[q]) m_def[q] = 0;
        forever begin
            @(posedge clk);
            begin
                bit el [NQ];
                bit adv;
                int n;
                longint sz;
                for (int q = 0; q < NQ; q++) el[q] = nempty_i[q] && (quantum_i[q] != 0);
                adv = 0;
                exp_val = 0;
                if (!srst_n_i) begin
                    m_phase = 0; m_ptr = 0; m_burst = 0;
                    exp_q = 0; exp_size = 0;
                    foreach (m_def[q]) m_def[q] = 0;
                end else begin
                    case (m_phase)
                        0: begin
                            n = find_next(m_ptr, 1, el);
                            if (n >= 0) begin m_ptr = n; m_phase = 1; end
                        end
                        1: begin
                            m_def[m_ptr] = m_def[m_ptr] + quantum_i[m_ptr];
                            if (m_def[m_ptr] > DMAX) m_def[m_ptr] = DMAX;
                            m_burst = 0;
                            m_phase = 2;
                        end
                        2: begin
                            sz = size_i[m_ptr];
                            if (!el[m_ptr]) begin
                                m_def[m_ptr] = 0;
                                adv = 1;
                            end else if (sz <= m_def[m_ptr] && m_burst < MB) begin
                                if (ready_i) begin
                                    exp_val = 1; exp_q = m_ptr; exp_size = int'(sz);
                                    m_def[m_ptr] -= sz;
                                    m_burst++;
                                    m_phase = 3;
                                end
                            end else begin
                                adv = 1;
                            end
                        end
                        default: m_phase = 2;
                    endcase
                    if (adv) begin
                        n = find_next(m_ptr, 0, el);
                        if (n >= 0) begin m_ptr = n; m_phase = 1; end
                        else m_phase = 0;
                    end
                end
            end
        end
    end

    // Compare process: DUT outputs and deficits against the model every cycle.
    initial begin
        foreach (cntq[q]) cntq[q] = 0;
        forever begin
            @(posedge clk);
            #1;
            check("read_val", read_val_o, exp_val);
            if (exp_val) begin
                check("read_q", read_o, exp_q);
                check("read_size", read_size_o, exp_size);
                gcnt++;
                cntq[exp_q]++;
                glog.push_back(exp_q);
            end
            for (int q = 0; q < NQ; q++) check($sformatf("deficit%0d", q), dut.deficit_q[q], m_def[q]);
        end
    end

    // Queue driver: pop granted heads, present new heads before the next edge.
    initial begin
        nempty_i = '0;
        size_i   = '0;
        forever begin
            @(negedge clk);
            if (exp_val && pq[exp_q].size() > 0) void'(pq[exp_q].pop_front());
            for (int q = 0; q < NQ; q++) begin
                if (pq[q].size() > 0) begin
                    nempty_i[q] = 1'b1;
                    size_i[q]   = SW'(pq[q][0]);
                end else begin
                    nempty_i[q] = 1'b0;
                    size_i[q]   = SW'($urandom);
                end
            end
        end
    end

    task automatic push(input int q, input int n, input int sz);
        for (int i = 0; i < n; i++) pq[q].push_back(sz);
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst_n_i = 1'b0;
        for (int q = 0; q < NQ; q++) pq[q].delete();
        @(posedge clk);
        #2;
        check("rst_read_val", read_val_o, 0);
        check("rst_read_o", read_o, 0);
        check("rst_read_size", read_size_o, 0);
        check("rst_ptr", dut.ptr_q, 0);
        for (int q = 0; q < NQ; q++) check("rst_deficit", dut.deficit_q[q], 0);
        @(negedge clk);
        srst_n_i = 1'b1;
        glog.delete();
        foreach (cntq[q]) cntq[q] = 0;
    endtask

    task automatic wait_grants(input int n, input string nm);
        int t0;
        int cyc;
        t0 = gcnt;
        cyc = 0;
        while (gcnt < t0 + n && cyc < 3000) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check({nm, "_reached"}, (gcnt >= t0 + n) ? 1 : 0, 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [QW-1:0] rand_quantum();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return QW'(0);
        else if (r == 9) return QW'(65535);
        else return QW'($urandom_range(50, 900));
    endfunction

    initial begin
        int pat [12];
        bit hit;
        srst_n_i  = 1'b0;
        ready_i   = 1'b1;
        quantum_i = '0;
        wait_cycles(2);

        // single backlogged queue: 2 grants then 3 grants
        do_reset();
        for (int q = 0; q < NQ; q++) quantum_i[q] = QW'(500);
        push(0, 20, 200);
        wait_grants(2, "t1a");
        check("t1_def_after2", m_def[0], 100);
        check("t1_dut_def_after2", dut.deficit_q[0], 100);
        wait_grants(3, "t1b");
        check("t1_def_after5", m_def[0], 0);
        check("t1_dut_def_after5", dut.deficit_q[0], 0);

        // weighted pattern 4:2
        do_reset();
        quantum_i = '0;
        quantum_i[0] = QW'(1000);
        quantum_i[1] = QW'(500);
        push(0, 40, 250);
        push(1, 40, 250);
        wait_grants(12, "t2");
        pat = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 12; i++) check($sformatf("t2_pattern%0d", i), glog[i], pat[i]);

        // disabled and empty queues never served
        do_reset();
        quantum_i[0] = QW'(300); quantum_i[1] = QW'(300);
        quantum_i[2] = QW'(0);   quantum_i[3] = QW'(300);
        push(0, 60, 100); push(2, 60, 100); push(3, 60, 100);
        wait_cycles(150);
        check("t3_q1_grants", cntq[1], 0);
        check("t3_q2_grants", cntq[2], 0);
        check("t3_q2_def", dut.deficit_q[2], 0);
        check("t3_q0_served", (cntq[0] > 0) ? 1 : 0, 1);
        @(negedge clk);
        quantum_i[2] = QW'(300);
        wait_cycles(100);
        check("t3_q2_served", (cntq[2] > 0) ? 1 : 0, 1);

        // drained queue forfeits credit; refill starts from its quantum
        do_reset();
        for (int q = 0; q < NQ; q++) quantum_i[q] = QW'(500);
        push(0, 2, 200);
        wait_grants(2, "t4a");
        check("t4_def_before_drain", dut.deficit_q[0], 100);
        wait_cycles(10);
        check("t4_def_cleared", m_def[0], 0);
        check("t4_dut_def_cleared", dut.deficit_q[0], 0);
        @(negedge clk);
        push(0, 3, 700);
        wait_grants(1, "t4b");
        check("t4_def_refill", dut.deficit_q[0], 300);
        check("t4_model_def_refill", m_def[0], 300);

        // backpressure holds the grant
        do_reset();
        ready_i = 1'b0;
        push(0, 5, 100);
        wait_cycles(12);
        check("t5_no_grant", gcnt - (gcnt - glog.size()), 0);
        check("t5_def_held", dut.deficit_q[0], 500);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("t5_grant_after_ready", read_val_o, 1);
        check("t5_grant_size", read_size_o, 100);
        wait_cycles(2);

        // zero-size packets bounded by the burst cap; deficit saturation
        do_reset();
        quantum_i = '0;
        quantum_i[2] = QW'(65535);
        push(2, 200, 0);
        wait_grants(4, "t6a");
        check("t6_def_visit1", dut.deficit_q[2], 65535);
        wait_grants(4, "t6b");
        check("t6_def_visit2", dut.deficit_q[2], 131070);
        wait_grants(12, "t6c");
        check("t6_def_sat", dut.deficit_q[2], DMAX);
        check("t6_model_def_sat", m_def[2], 262143);

        // randomized traffic
        do_reset();
        for (int q = 0; q < NQ; q++) quantum_i[q] = rand_quantum();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int q;
                q = $urandom_range(0, NQ - 1);
                if (pq[q].size() < 8) pq[q].push_back($urandom_range(0, 700));
            end
            if (c % 200 == 199) quantum_i[$urandom_range(0, NQ - 1)] = rand_quantum();
        end

        // reset while a grant is being settled
        ready_i = 1'b1;
        for (int q = 0; q < NQ; q++) quantum_i[q] = QW'(400);
        hit = 0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk);
            if (pq[1].size() < 4) pq[1].push_back(120);
            @(posedge clk);
            #2;
            if (exp_val && exp_q != 0) hit = 1;
        end
        check("settle_grant_seen", hit, 1);
        @(negedge clk);
        srst_n_i = 1'b0;
        @(posedge clk);
        #2;
        check("settle_rst_val", read_val_o, 0);
        check("settle_rst_read", read_o, 0);
        check("settle_rst_size", read_size_o, 0);
        check("settle_rst_ptr", dut.ptr_q, 0);
        for (int q = 0; q < NQ; q++) check("settle_rst_def", dut.deficit_q[q], 0);
        @(negedge clk);
        srst_n_i = 1'b1;
        wait_cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
